qupls_fpu_sched: RTL and testbench

- Issue scheduler for the FPU reservation station.
- Each cycle it selects the oldest FP-ready ROB entry, relative to the ROB head, and presents its index to the station with rndxv/idle.
- It holds the station off (idle=0) while a multicycle FP op is executing, until the op completes or a watchdog expires.
- It sits between the ROB ready-scan logic and the FPU station.

---
 rtl/qupls_fpu_sched.sv | 108 ++++++++++
 tb/tb_qupls_fpu_sched.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/qupls_fpu_sched.sv
// rtl/qupls_fpu_sched.sv - FPU reservation station issue scheduler
// Picks the oldest FP-ready ROB entry relative to head and holds off issue during multicycle ops.
module qupls_fpu_sched #(
  parameter int NENTRY = 16,
  parameter int NDXW   = $clog2(NENTRY),
  parameter int TMO    = 64,
  parameter int TMOW   = $clog2(TMO+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NDXW-1:0]   head,
  input  logic [NENTRY-1:0] req,
  input  logic [NENTRY-1:0] mc,
  input  logic              available,
  input  logic              fpu_done,
  input  logic              flush,
  output logic [NDXW-1:0]   rndx,
  output logic              rndxv,
  output logic              idle,
  output logic [NENTRY-1:0] issued,
  output logic              tmo_err
);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT_MC = 1'b1} state_t;

  state_t            state;
  logic [TMOW-1:0]   counter;
  logic [NENTRY-1:0] lastMask;
  logic [NENTRY-1:0] elig;
  logic [2*NENTRY-1:0] dbl;
  logic [NENTRY-1:0] rot;
  logic [NDXW-1:0]   pos;
  logic [NDXW-1:0]   sel;
  logic [NENTRY-1:0] selOh;
  logic              anyElig;

  // Entry granted last cycle is masked while the ROB catches up on clearing its bit.
  assign elig = req & ~lastMask;
  assign dbl  = {elig, elig} >> head;
  assign rot  = dbl[NENTRY-1:0];
  assign anyElig = |rot;

  always_comb begin
    pos = '0;
    for (int i = NENTRY-1; i >= 0; i--)
      if (rot[i]) pos = NDXW'(i);
  end

  assign sel   = head + pos;
  assign selOh = NENTRY'(1) << sel;
  assign idle  = (state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rndx     <= '0;
      rndxv    <= 1'b0;
      issued   <= '0;
      tmo_err  <= 1'b0;
      counter  <= '0;
      lastMask <= '0;
    end else if (flush) begin
      state    <= IDLE;
      rndxv    <= 1'b0;
      issued   <= '0;
      tmo_err  <= 1'b0;
      counter  <= '0;
      lastMask <= '0;
    end else begin
      case (state)
        IDLE: begin
          tmo_err <= 1'b0;
          if (available && anyElig) begin
            rndx     <= sel;
            rndxv    <= 1'b1;
            issued   <= selOh;
            lastMask <= selOh;
            if (mc[sel]) begin
              state   <= WAIT_MC;
              counter <= '0;
            end
          end else begin
            rndxv    <= 1'b0;
            issued   <= '0;
            lastMask <= '0;
          end
        end
        WAIT_MC: begin
          rndxv    <= 1'b0;
          issued   <= '0;
          lastMask <= '0;
          counter  <= counter + 1'b1;
          // Completion beats the watchdog when both land together.
          if (fpu_done) begin
            state   <= IDLE;
            counter <= '0;
          end else if (counter == TMOW'(TMO-1)) begin
            state   <= IDLE;
            counter <= '0;
            tmo_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qupls_fpu_sched.sv
// tb/tb_qupls_fpu_sched.sv - directed-vector bench for qupls_fpu_sched
module tb_qupls_fpu_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  head;
  logic [15:0] req, mc;
  logic        available, fpu_done, flush;
  logic [3:0]  rndx;
  logic        rndxv, idle, tmo_err;
  logic [15:0] issued;

  int vecCount  = 0;
  int missCount = 0;

  qupls_fpu_sched #(.NENTRY(16), .TMO(64)) dut (
    .clk(clk), .rst(rst), .head(head), .req(req), .mc(mc),
    .available(available), .fpu_done(fpu_done), .flush(flush),
    .rndx(rndx), .rndxv(rndxv), .idle(idle), .issued(issued), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chkOut(input string tag, input logic [3:0] eNdx, input logic eV,
                        input logic [15:0] eIss, input logic eIdle, input logic eTmo);
    chk({tag, ".rndx"},    32'(rndx),    32'(eNdx));
    chk({tag, ".rndxv"},   32'(rndxv),   32'(eV));
    chk({tag, ".issued"},  32'(issued),  32'(eIss));
    chk({tag, ".idle"},    32'(idle),    32'(eIdle));
    chk({tag, ".tmo_err"}, 32'(tmo_err), 32'(eTmo));
  endtask

  initial begin
    rst = 1'b0; head = '0; req = '0; mc = '0;
    available = 1'b1; fpu_done = 1'b0; flush = 1'b0;
    #1;
    chkOut("reset", 4'd0, 1'b0, 16'h0, 1'b1, 1'b0);
    step(); step();
    rst = 1'b1;
    step();
    chkOut("post_reset", 4'd0, 1'b0, 16'h0, 1'b1, 1'b0);

    // oldest-first relative to head
    head = 4'd5; req = 16'h0101;
    step();
    chkOut("h5_c1", 4'd8, 1'b1, 16'h0100, 1'b1, 1'b0);
    req = 16'h0001;
    step();
    chkOut("h5_c2", 4'd0, 1'b1, 16'h0001, 1'b1, 1'b0);
    req = 16'h0;
    step();
    chkOut("h5_quiet", 4'd0, 1'b0, 16'h0, 1'b1, 1'b0);

    // wrap and last-grant masking
    head = 4'd15; req = 16'h8001;
    step();
    chkOut("wrap_c1", 4'd15, 1'b1, 16'h8000, 1'b1, 1'b0);
    step();
    chkOut("wrap_c2", 4'd0, 1'b1, 16'h0001, 1'b1, 1'b0);
    step();
    chkOut("wrap_c3", 4'd15, 1'b1, 16'h8000, 1'b1, 1'b0);
    req = 16'h0;
    step(); step();
    chkOut("wrap_quiet", 4'd15, 1'b0, 16'h0, 1'b1, 1'b0);

    // available=0 blocks issue
    head = 4'd0; req = 16'h0001; available = 1'b0;
    step();
    chkOut("unavail", 4'd15, 1'b0, 16'h0, 1'b1, 1'b0);
    req = 16'h0; available = 1'b1;
    fpu_done = 1'b1;
    step();
    chkOut("done_in_idle", 4'd15, 1'b0, 16'h0, 1'b1, 1'b0);
    fpu_done = 1'b0;

    // multicycle op completed by fpu_done
    req = 16'h0004; mc = 16'h0004;
    step();
    chkOut("mc_grant", 4'd2, 1'b1, 16'h0004, 1'b0, 1'b0);
    req = 16'h0010; mc = 16'h0;
    for (int k = 1; k < 10; k++) step();
    chkOut("mc_hold", 4'd2, 1'b0, 16'h0, 1'b0, 1'b0);
    fpu_done = 1'b1;
    step();
    chkOut("mc_done", 4'd2, 1'b0, 16'h0, 1'b1, 1'b0);
    fpu_done = 1'b0;
    step();
    chkOut("mc_resume", 4'd4, 1'b1, 16'h0010, 1'b1, 1'b0);
    req = 16'h0;
    step();

    // watchdog expiry 64 cycles after entering WAIT_MC
    req = 16'h0004; mc = 16'h0004;
    step();
    chkOut("tmo_grant", 4'd2, 1'b1, 16'h0004, 1'b0, 1'b0);
    req = 16'h0;
    for (int k = 1; k < 64; k++) step();
    chkOut("tmo_c63", 4'd2, 1'b0, 16'h0, 1'b0, 1'b0);
    step();
    chkOut("tmo_c64", 4'd2, 1'b0, 16'h0, 1'b1, 1'b1);
    step();
    chkOut("tmo_after", 4'd2, 1'b0, 16'h0, 1'b1, 1'b0);

    // done in the timeout cycle wins
    req = 16'h0004;
    step();
    chkOut("tmo2_grant", 4'd2, 1'b1, 16'h0004, 1'b0, 1'b0);
    req = 16'h0;
    for (int k = 1; k < 64; k++) step();
    fpu_done = 1'b1;
    step();
    chkOut("tmo2_done", 4'd2, 1'b0, 16'h0, 1'b1, 1'b0);
    fpu_done = 1'b0;
    mc = 16'h0;

    // flush in IDLE suppresses the grant
    head = 4'd0; req = 16'hFFFF; flush = 1'b1;
    step();
    chkOut("flush_idle", 4'd2, 1'b0, 16'h0, 1'b1, 1'b0);
    flush = 1'b0;
    step();
    chkOut("after_flush", 4'd0, 1'b1, 16'h0001, 1'b1, 1'b0);
    req = 16'h0;
    step();

    // flush during WAIT_MC, then full watchdog proves counter restarted
    req = 16'h0004; mc = 16'h0004;
    step();
    req = 16'h0;
    for (int k = 1; k < 40; k++) step();
    flush = 1'b1;
    step();
    chkOut("flush_mc", 4'd2, 1'b0, 16'h0, 1'b1, 1'b0);
    flush = 1'b0;
    req = 16'h0004;
    step();
    chkOut("reflush_grant", 4'd2, 1'b1, 16'h0004, 1'b0, 1'b0);
    req = 16'h0;
    for (int k = 1; k < 64; k++) step();
    chkOut("reflush_c63", 4'd2, 1'b0, 16'h0, 1'b0, 1'b0);
    step();
    chkOut("reflush_c64", 4'd2, 1'b0, 16'h0, 1'b1, 1'b1);

    // asynchronous reset mid-WAIT_MC
    req = 16'h0008; mc = 16'h0008;
    step();
    chkOut("rst_grant", 4'd3, 1'b1, 16'h0008, 1'b0, 1'b0);
    req = 16'h0; mc = 16'h0;
    step(); step();
    #2 rst = 1'b0;
    #1;
    chkOut("async_rst", 4'd0, 1'b0, 16'h0, 1'b1, 1'b0);
    step();
    rst = 1'b1;
    step(); step();
    chkOut("rst_release", 4'd0, 1'b0, 16'h0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
